// File: rtl/rv_pkg.sv
// Shared integer-core definitions: widths, register index type, writeback source.
package rv_pkg;
    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = $clog2(NREGS);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        WB_ALU  = 1'b0,
        WB_LONG = 1'b1
    } wb_src_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grant is combinational.
// The priority pointer only moves when both sides request.
module rr_arbiter2
    import rv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_l,
    output logic gnt_a,
    output logic gnt_l
);
    // Source that wins the next contested cycle.
    wb_src_e prio;

    // Uncontested requests always win; contested ones go to the pointer.
    always_comb begin
        gnt_a = req_a && (!req_l || (prio == WB_ALU));
        gnt_l = req_l && (!req_a || (prio == WB_LONG));
    end

    // After a contested grant, hand priority to the loser.
    always_ff @(posedge clk) begin
        if (rst)
            prio <= WB_ALU;
        else if (req_a && req_l)
            prio <= gnt_a ? WB_LONG : WB_ALU;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: arbitrates ALU and long-latency writebacks,
// tracks outstanding long-latency destinations and stalls issue on hazards.
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREGS = rv_pkg::NREGS,
    localparam int IW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [IW-1:0]   iss_rs1,
    input  logic [IW-1:0]   iss_rs2,
    input  logic [IW-1:0]   iss_rd,
    input  logic            iss_long,
    output logic            iss_stall,
    input  logic            a_valid,
    input  logic [IW-1:0]   a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            l_valid,
    input  logic [IW-1:0]   l_rd,
    input  logic [XLEN-1:0] l_data,
    output logic            l_ready,
    output logic            rf_we,
    output logic [IW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata
);
    // x0 can never be busy.
    localparam logic [NREGS-1:0] X0_MASK = {{(NREGS-1){1'b1}}, 1'b0};

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_set;
    logic [NREGS-1:0] busy_clr;
    wb_src_e          wb_src;
    logic             gnt_a;
    logic             gnt_l;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_a (a_valid),
        .req_l (l_valid),
        .gnt_a (gnt_a),
        .gnt_l (gnt_l)
    );

    assign a_ready = gnt_a;
    assign l_ready = gnt_l;

    // Hold issue on RAW against pending L writes, and on WAW for non-x0 rd.
    always_comb begin
        iss_stall = iss_valid && (busy[iss_rs1] || busy[iss_rs2] ||
                                  (busy[iss_rd] && (iss_rd != '0)));
    end

    // Writeback register stage: one cycle from grant to rf_we; rd==0 writes nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            wb_src   <= WB_ALU;
        end else if (gnt_a) begin
            rf_we    <= (a_rd != '0);
            rf_rd    <= a_rd;
            rf_wdata <= a_data;
            wb_src   <= WB_ALU;
        end else if (gnt_l) begin
            rf_we    <= (l_rd != '0);
            rf_rd    <= l_rd;
            rf_wdata <= l_data;
            wb_src   <= WB_LONG;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Scoreboard set on accepted long issue, clear when the L result hits the file.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_valid && !iss_stall && iss_long && (iss_rd != '0))
            busy_set[iss_rd] = 1'b1;
        if (rf_we && (wb_src == WB_LONG))
            busy_clr[rf_rd] = 1'b1;
    end

    // Set dominates clear on the same index.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= ((busy & ~busy_clr) | busy_set) & X0_MASK;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: one task per scenario.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_long;
    logic        iss_stall;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        l_valid;
    logic [4:0]  l_rd;
    logic [31:0] l_data;
    logic        l_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
        .iss_rd(iss_rd), .iss_long(iss_long), .iss_stall(iss_stall),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .l_valid(l_valid), .l_rd(l_rd), .l_data(l_data), .l_ready(l_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_long = 0;
        a_valid = 0; a_rd = 0; a_data = 0;
        l_valid = 0; l_rd = 0; l_data = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        // Build up state: busy[4] via long issue, rf_we=1 via ALU write.
        iss_valid = 1; iss_long = 1; iss_rd = 4;
        a_valid = 1; a_rd = 5; a_data = 32'h0000_1111;
        step();
        idle();
        iss_valid = 1; iss_rs1 = 4;
        #1;
        n_cmp++;
        if (iss_stall !== 1'b1) begin
            n_err++; $display("FAIL reset_pre_stall: got %b want 1", iss_stall);
        end
        n_cmp++;
        if (rf_we !== 1'b1) begin
            n_err++; $display("FAIL reset_pre_we: got %b want 1", rf_we);
        end
        idle();
        rst = 1;
        step();
        rst = 0;
        n_cmp++;
        if ({rf_we, rf_rd, rf_wdata} !== 38'd0) begin
            n_err++; $display("FAIL reset_outputs: we=%b rd=%0d wdata=%h want 0/0/0", rf_we, rf_rd, rf_wdata);
        end
        iss_valid = 1; iss_rs1 = 4; iss_rs2 = 4; iss_rd = 4;
        #1;
        n_cmp++;
        if (iss_stall !== 1'b0) begin
            n_err++; $display("FAIL reset_stall: got %b want 0", iss_stall);
        end
        idle();
    endtask

    task automatic test_single_alu();
        do_reset();
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if ({a_ready, l_ready} !== 2'b10) begin
            n_err++; $display("FAIL alu_ready: got a=%b l=%b want a=1 l=0", a_ready, l_ready);
        end
        step();
        idle();
        n_cmp++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL alu_wb: we=%b rd=%0d wdata=%h want 1/5/deadbeef", rf_we, rf_rd, rf_wdata);
        end
        step();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++; $display("FAIL alu_we_drop: got %b want 0", rf_we);
        end
    endtask

    task automatic test_contested();
        logic exp_a;
        do_reset();
        a_valid = 1; a_rd = 3; a_data = 32'hAAAA_0003;
        l_valid = 1; l_rd = 7; l_data = 32'h5555_0007;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            #1;
            n_cmp++;
            if ({a_ready, l_ready} !== {exp_a, !exp_a}) begin
                n_err++; $display("FAIL contest_grant[%0d]: got a=%b l=%b want a=%b l=%b", i, a_ready, l_ready, exp_a, !exp_a);
            end
            step();
            n_cmp++;
            if ({rf_we, rf_rd, rf_wdata} !== (exp_a ? {1'b1, 5'd3, 32'hAAAA_0003} : {1'b1, 5'd7, 32'h5555_0007})) begin
                n_err++; $display("FAIL contest_wb[%0d]: we=%b rd=%0d wdata=%h want rd=%0d", i, rf_we, rf_rd, rf_wdata, exp_a ? 3 : 7);
            end
        end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        iss_valid = 1; iss_long = 1; iss_rd = 9;
        #1;
        n_cmp++;
        if (iss_stall !== 1'b0) begin
            n_err++; $display("FAIL lu_issue: got %b want 0", iss_stall);
        end
        step();
        idle();
        iss_valid = 1; iss_rs1 = 9; iss_rd = 10;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (iss_stall !== 1'b1) begin
                n_err++; $display("FAIL lu_stall[%0d]: got %b want 1", i, iss_stall);
            end
            step();
        end
        l_valid = 1; l_rd = 9; l_data = 32'h0000_1234;
        #1;
        n_cmp++;
        if ({l_ready, iss_stall} !== 2'b11) begin
            n_err++; $display("FAIL lu_grant_t: l_ready=%b stall=%b want 1/1", l_ready, iss_stall);
        end
        step();
        l_valid = 0;
        #1;
        n_cmp++;
        if ({rf_we, rf_rd, rf_wdata, iss_stall} !== {1'b1, 5'd9, 32'h0000_1234, 1'b1}) begin
            n_err++; $display("FAIL lu_t1: we=%b rd=%0d wdata=%h stall=%b want 1/9/1234/1", rf_we, rf_rd, rf_wdata, iss_stall);
        end
        step();
        n_cmp++;
        if (iss_stall !== 1'b0) begin
            n_err++; $display("FAIL lu_t2: got %b want 0", iss_stall);
        end
        idle();
    endtask

    task automatic test_waw_x0();
        do_reset();
        iss_valid = 1; iss_long = 1; iss_rd = 0;
        step();
        iss_rd = 12;
        step();
        idle();
        iss_valid = 1; iss_rs1 = 1; iss_rs2 = 2; iss_rd = 12;
        #1;
        n_cmp++;
        if (iss_stall !== 1'b1) begin
            n_err++; $display("FAIL waw_stall: got %b want 1", iss_stall);
        end
        iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        #1;
        n_cmp++;
        if (iss_stall !== 1'b0) begin
            n_err++; $display("FAIL x0_not_busy: got %b want 0", iss_stall);
        end
        idle();
        a_valid = 1; a_rd = 0; a_data = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (a_ready !== 1'b1) begin
            n_err++; $display("FAIL x0_a_ready: got %b want 1", a_ready);
        end
        step();
        idle();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++; $display("FAIL x0_we: got %b want 0", rf_we);
        end
        // Both rd==0: still one grant, still no write.
        a_valid = 1; l_valid = 1;
        #1;
        n_cmp++;
        if ((a_ready ^ l_ready) !== 1'b1) begin
            n_err++; $display("FAIL x0_both_grant: got a=%b l=%b want exactly one", a_ready, l_ready);
        end
        step();
        idle();
        n_cmp++;
        if (rf_we !== 1'b0) begin
            n_err++; $display("FAIL x0_both_we: got %b want 0", rf_we);
        end
        // L write to a non-busy register: normal write, busy[12] untouched.
        l_valid = 1; l_rd = 20; l_data = 32'hCAFE_0020;
        step();
        idle();
        iss_valid = 1; iss_rs1 = 12;
        #1;
        n_cmp++;
        if ({rf_we, rf_rd, rf_wdata, iss_stall} !== {1'b1, 5'd20, 32'hCAFE_0020, 1'b1}) begin
            n_err++; $display("FAIL l_nonbusy: we=%b rd=%0d wdata=%h stall=%b want 1/20/cafe0020/1", rf_we, rf_rd, rf_wdata, iss_stall);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        iss_valid = 1; iss_long = 1; iss_rd = 4;
        step();
        idle();
        l_valid = 1; l_rd = 4; l_data = 32'h4444_4444;
        rst = 1;
        step();
        rst = 0;
        idle();
        iss_valid = 1; iss_rs1 = 4;
        #1;
        n_cmp++;
        if ({rf_we, iss_stall} !== 2'b00) begin
            n_err++; $display("FAIL reset_mid: we=%b stall=%b want 0/0", rf_we, iss_stall);
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_single_alu();
        test_contested();
        test_load_use();
        test_waw_x0();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
